// File: rtl/cmem_ctrl.sv
// Coefficient-memory controller: streams host taps into a banked coefficient RAM
// and reads them back NBANK taps per cycle. Enables lag address/data by one cycle.
module cmem_ctrl #(
  parameter int NBANK = 8,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coef_valid,
  output logic             coef_ready,
  input  logic [15:0]      coef_data,
  input  logic             coef_last,
  input  logic             run_start,
  output logic             run_done,
  output logic             busy,
  output logic [6:0]       ntaps,
  output logic [15:0]      mem_d,
  output logic [AW-1:0]    mem_a7,
  output logic [AW-1:0]    mem_a6,
  output logic [AW-1:0]    mem_a5,
  output logic [AW-1:0]    mem_a4,
  output logic [AW-1:0]    mem_a3,
  output logic [AW-1:0]    mem_a2,
  output logic [AW-1:0]    mem_a1,
  output logic [AW-1:0]    mem_a0,
  output logic             mem_wen_n,
  output logic             mem_cen_n,
  output logic             rd_valid,
  output logic [NBANK-1:0] rd_lane
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [7:0] NB = 8'(NBANK);

  state_t             state_reg, state_next;
  logic [AW-1:0]      wptr_reg;
  logic [6:0]         ntaps_reg;
  logic [7:0]         rbase_reg;
  logic [15:0]        mem_d_reg, mem_d_next;
  logic               wen_n_reg, cen_n_reg;
  logic               rd_valid_reg;
  logic [NBANK-1:0]   rd_lane_reg, rd_lane_next;
  logic               run_done_reg, run_done_next;
  logic [AW-1:0]      addr_reg  [8];
  logic [AW-1:0]      addr_next [8];

  logic               acc;
  logic               term;
  logic               rd_act;
  logic               rd_last;
  logic [AW-1:0]      n_addr;

  // A new load always starts at address 0; only LOAD continues from the pointer.
  assign acc     = coef_valid && (state_reg != RUN);
  assign n_addr  = (state_reg == LOAD) ? wptr_reg : '0;
  assign term    = acc && (coef_last || (n_addr == '1));
  assign rd_act  = (state_reg == RUN) && (rbase_reg < {1'b0, ntaps_reg});
  assign rd_last = (rbase_reg + NB) >= {1'b0, ntaps_reg};

  always_comb begin
    state_next    = state_reg;
    run_done_next = 1'b0;
    mem_d_next    = mem_d_reg;
    if (acc) begin
      mem_d_next = coef_data;
    end
    case (state_reg)
      IDLE: begin
        if (acc) begin
          state_next = term ? IDLE : LOAD;
        end else if (run_start) begin
          state_next = RUN;
          // An empty table finishes on the very next cycle with no reads.
          run_done_next = (ntaps_reg == 7'd0);
        end
      end
      LOAD: begin
        if (term) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (!rd_act || rd_last) begin
          state_next = IDLE;
        end
        if (rd_act && rd_last) begin
          run_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_addr
      always_comb begin
        addr_next[gi] = addr_reg[gi];
        if (acc) begin
          addr_next[gi] = n_addr;
        end else if (rd_act) begin
          addr_next[gi] = AW'(rbase_reg + 8'(gi));
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          addr_reg[gi] <= '0;
        end else begin
          addr_reg[gi] <= addr_next[gi];
        end
      end
    end

    for (gi = 0; gi < NBANK; gi++) begin : g_lane
      assign rd_lane_next[gi] = rd_act && ((rbase_reg + 8'(gi)) < {1'b0, ntaps_reg});
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wptr_reg     <= '0;
      ntaps_reg    <= '0;
      rbase_reg    <= '0;
      mem_d_reg    <= '0;
      wen_n_reg    <= 1'b1;
      cen_n_reg    <= 1'b1;
      rd_valid_reg <= 1'b0;
      rd_lane_reg  <= '0;
      run_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mem_d_reg    <= mem_d_next;
      wen_n_reg    <= !acc;
      cen_n_reg    <= !(acc || rd_act);
      rd_valid_reg <= rd_act;
      rd_lane_reg  <= rd_lane_next;
      run_done_reg <= run_done_next;
      if (acc) begin
        wptr_reg <= n_addr + AW'(1);
      end
      if (term) begin
        ntaps_reg <= 7'(n_addr) + 7'd1;
      end
      if (state_reg != RUN) begin
        rbase_reg <= '0;
      end else if (rd_act) begin
        rbase_reg <= rbase_reg + NB;
      end
    end
  end

  assign coef_ready = (state_reg != RUN);
  assign busy       = (state_reg != IDLE);
  assign ntaps      = ntaps_reg;
  assign mem_d      = mem_d_next;
  assign mem_wen_n  = wen_n_reg;
  assign mem_cen_n  = cen_n_reg;
  assign rd_valid   = rd_valid_reg;
  assign rd_lane    = rd_lane_reg;
  assign run_done   = run_done_reg;
  assign mem_a0     = addr_next[0];
  assign mem_a1     = addr_next[1];
  assign mem_a2     = addr_next[2];
  assign mem_a3     = addr_next[3];
  assign mem_a4     = addr_next[4];
  assign mem_a5     = addr_next[5];
  assign mem_a6     = addr_next[6];
  assign mem_a7     = addr_next[7];

endmodule

// File: tb/tb_cmem_ctrl.sv
// Directed bench for cmem_ctrl: loads, banked reads, empty run, priority and reset abort.
module tb_cmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic [15:0] coef_data = 16'h0;
  logic        coef_last = 1'b0;
  logic        run_start = 1'b0;
  logic        run_done;
  logic        busy;
  logic [6:0]  ntaps;
  logic [15:0] mem_d;
  logic [5:0]  mem_a7, mem_a6, mem_a5, mem_a4, mem_a3, mem_a2, mem_a1, mem_a0;
  logic        mem_wen_n;
  logic        mem_cen_n;
  logic        rd_valid;
  logic [7:0]  rd_lane;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int rdv_cnt  = 0;

  logic [47:0] a_all;
  assign a_all = {mem_a7, mem_a6, mem_a5, mem_a4, mem_a3, mem_a2, mem_a1, mem_a0};

  cmem_ctrl #(.NBANK(8), .AW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_data  (coef_data),
    .coef_last  (coef_last),
    .run_start  (run_start),
    .run_done   (run_done),
    .busy       (busy),
    .ntaps      (ntaps),
    .mem_d      (mem_d),
    .mem_a7     (mem_a7),
    .mem_a6     (mem_a6),
    .mem_a5     (mem_a5),
    .mem_a4     (mem_a4),
    .mem_a3     (mem_a3),
    .mem_a2     (mem_a2),
    .mem_a1     (mem_a1),
    .mem_a0     (mem_a0),
    .mem_wen_n  (mem_wen_n),
    .mem_cen_n  (mem_cen_n),
    .rd_valid   (rd_valid),
    .rd_lane    (rd_lane)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && run_done) done_cnt++;
    if (!rst && rd_valid) rdv_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, leave time to settle before sampling.
  task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic rs);
    @(posedge clk);
    #1;
    coef_valid = v;
    coef_data  = d;
    coef_last  = l;
    run_start  = rs;
    #3;
  endtask

  function automatic logic [47:0] wr_addr(input int n);
    logic [5:0] a;
    a = 6'(n);
    return {8{a}};
  endfunction

  function automatic logic [47:0] rd_addr(input int b);
    logic [47:0] r;
    r = '0;
    for (int x = 0; x < 8; x++) r[x*6 +: 6] = 6'(b + x);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_busy", busy, 0);
    chk("rst_ntaps", ntaps, 0);
    chk("rst_wen", mem_wen_n, 1);
    chk("rst_cen", mem_cen_n, 1);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_lane", rd_lane, 0);
    chk("rst_done", run_done, 0);
    chk("rst_memd", mem_d, 0);
    chk("rst_addr", a_all, 0);
    chk("rst_ready", coef_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Empty run: done one cycle later, no reads, no enable.
    r0 = rdv_cnt;
    drive(0, 16'h0, 0, 1);
    chk("e0_done", run_done, 0);
    drive(0, 16'h0, 0, 0);
    chk("e1_done", run_done, 1);
    chk("e1_cen", mem_cen_n, 1);
    chk("e1_rdv", rd_valid, 0);
    drive(0, 16'h0, 0, 0);
    chk("e2_done", run_done, 0);
    chk("e2_cen", mem_cen_n, 1);
    chk("e2_busy", busy, 0);
    chk("e_rdvcnt", rdv_cnt, r0);

    // Three-word load, back to back.
    drive(1, 16'h0011, 0, 0);
    chk("l3_a0", a_all, wr_addr(0));
    chk("l3_d0", mem_d, 16'h0011);
    chk("l3_wen0", mem_wen_n, 1);
    drive(1, 16'h0022, 0, 0);
    chk("l3_a1", a_all, wr_addr(1));
    chk("l3_wen1", mem_wen_n, 0);
    chk("l3_busy", busy, 1);
    drive(1, 16'h0033, 1, 0);
    chk("l3_a2", a_all, wr_addr(2));
    chk("l3_d2", mem_d, 16'h0033);
    chk("l3_wen2", mem_wen_n, 0);
    drive(0, 16'h0, 0, 0);
    chk("l3_wen3", mem_wen_n, 0);
    chk("l3_cen3", mem_cen_n, 0);
    chk("l3_ntaps", ntaps, 3);
    chk("l3_busyoff", busy, 0);
    chk("l3_ahold", a_all, wr_addr(2));
    chk("l3_dhold", mem_d, 16'h0033);
    drive(0, 16'h0, 0, 0);
    chk("l3_wen4", mem_wen_n, 1);

    // Ten-word load with a run_start inside LOAD that must be ignored.
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      drive(1, 16'(16'h0100 + i), (i == 9), (i == 4));
      chk($sformatf("l10_a%0d", i), a_all, wr_addr(i));
    end
    drive(0, 16'h0, 0, 0);
    chk("l10_ntaps", ntaps, 10);
    chk("l10_busy", busy, 0);
    drive(0, 16'h0, 0, 0);
    chk("l10_nodone", done_cnt, d0);

    // Run over ten taps: two read cycles; run_start during RUN ignored.
    drive(0, 16'h0, 0, 1);
    drive(0, 16'h0, 0, 1);
    chk("r1_busy", busy, 1);
    chk("r1_a", a_all, rd_addr(0));
    chk("r1_rdv", rd_valid, 0);
    chk("r1_ready", coef_ready, 0);
    drive(0, 16'h0, 0, 0);
    chk("r2_a", a_all, rd_addr(8));
    chk("r2_rdv", rd_valid, 1);
    chk("r2_lane", rd_lane, 8'hFF);
    chk("r2_cen", mem_cen_n, 0);
    chk("r2_wen", mem_wen_n, 1);
    chk("r2_done", run_done, 0);
    drive(0, 16'h0, 0, 0);
    chk("r3_rdv", rd_valid, 1);
    chk("r3_lane", rd_lane, 8'h03);
    chk("r3_done", run_done, 1);
    chk("r3_cen", mem_cen_n, 0);
    chk("r3_busy", busy, 0);
    chk("r3_ahold", a_all, rd_addr(8));
    drive(0, 16'h0, 0, 0);
    chk("r4_rdv", rd_valid, 0);
    chk("r4_done", run_done, 0);
    chk("r4_cen", mem_cen_n, 1);
    chk("r4_busy", busy, 0);

    // Load and run requested together: load wins, no run_done.
    d0 = done_cnt;
    drive(1, 16'h0055, 0, 1);
    chk("p0_a", a_all, wr_addr(0));
    drive(1, 16'h0066, 1, 0);
    chk("p1_busy", busy, 1);
    chk("p1_a", a_all, wr_addr(1));
    drive(0, 16'h0, 0, 0);
    chk("p2_ntaps", ntaps, 2);
    repeat (3) drive(0, 16'h0, 0, 0);
    chk("p_nodone", done_cnt, d0);

    // 64 words with no last: ends at 63, 65th word restarts at 0.
    for (int i = 0; i < 64; i++) begin
      drive(1, 16'(16'h1000 + i), 0, 0);
      chk($sformatf("l64_a%0d", i), a_all, wr_addr(i));
    end
    drive(1, 16'hAAAA, 0, 0);
    chk("l64_busy", busy, 0);
    chk("l64_ntaps", ntaps, 64);
    chk("l65_a", a_all, wr_addr(0));
    chk("l65_d", mem_d, 16'hAAAA);
    chk("l64_wen", mem_wen_n, 0);
    drive(1, 16'hBBBB, 1, 0);
    chk("l66_busy", busy, 1);
    chk("l66_a", a_all, wr_addr(1));
    drive(0, 16'h0, 0, 0);
    chk("l66_ntaps", ntaps, 2);

    // Reset between a write's address cycle and its enable cycle.
    drive(1, 16'h0077, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    #3;
    chk("ra_wen", mem_wen_n, 1);
    chk("ra_cen", mem_cen_n, 1);
    chk("ra_ntaps", ntaps, 0);
    chk("ra_busy", busy, 0);
    chk("ra_memd", mem_d, 0);
    drive(0, 16'h0, 0, 0);
    chk("ra_wen2", mem_wen_n, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
